truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE, default 1: number of cycles each input combination is held before S is sampled; legal range 1..15.
REQ-002 Parameter EXPECTED, default 16'h0675: golden 16-entry truth table, bit i = expected S for index i.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  scan request, sampled on rising clk edges.
REQ-007 S  input  1  response of the combinational function under scan.
REQ-008 X1, X2, X3, X4  output  1 each  stimulus to the function under scan; X1 = idx[0], X2 = idx[1], X3 = idx[2], X4 = idx[3].
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  high from scan completion until the next accepted start.
REQ-011 table_out  output  16  captured truth table, bit i = S sampled for index i.

Function
REQ-012 FSM states: IDLE, SETTLE, SAMPLE, DONE; state, idx[3:0], settle counter and table register are registered on clk.
REQ-013 IDLE or DONE with start=1 at an edge: next state SETTLE, idx=0, settle counter=0, table_out=16'h0000, busy=1, done=0.
REQ-014 X1..X4 are registered, equal idx during SETTLE and SAMPLE, and are 0 in IDLE and DONE.
REQ-015 SETTLE: counter increments each cycle; after SETTLE cycles in SETTLE, next state is SAMPLE.
REQ-016 SAMPLE lasts exactly one cycle; at its closing edge table_out[idx] <= S.
REQ-017 SAMPLE with idx<15: idx increments, counter clears, next state SETTLE; no idle gap between indices.
REQ-018 SAMPLE with idx=15: next state DONE, busy=0, done=1; idx does not wrap into a new scan.
REQ-019 Latency: start accepted at edge k; done rises at edge k + 16*(SETTLE+1), i.e. k+32 for SETTLE=1.
REQ-020 start while busy=1 is ignored; the scan in progress and table_out are unaffected.
REQ-021 DONE holds done=1 and table_out stable indefinitely while start=0.
REQ-022 table_out bits for indices not yet sampled read 0 during a scan; only the value with done=1 is valid.
REQ-023 Continuous start=1: a new scan is accepted on the first edge in DONE, giving back-to-back scans with done high for exactly one cycle.

Reset
REQ-024 rst_n=0 asynchronously forces state=IDLE, idx=0, counter=0, X1..X4=0, busy=0, done=0, table_out=16'h0000, independent of clk.
REQ-025 Reset mid-scan aborts the scan with no partial result retained; after release, start is required before any activity.
REQ-026 The first edge after rst_n rises with start=1 is accepted normally.

Configuration
REQ-027 Macro SCAN_CHECK_EN defined: adds outputs mismatch (1) and mismatch_map (16); mismatch_map = table_out ^ EXPECTED and mismatch = |mismatch_map, both qualified by done (0 when done=0 and on reset).
REQ-028 SCAN_CHECK_EN undefined: those ports and their logic do not exist; all other behaviour is identical.

Verification
REQ-029 SETTLE=1, S driven by the golden model of EXPECTED, pulse start -> done at edge k+32, table_out=16'h0675, mismatch=0.
REQ-030 S tied to 1 -> table_out=16'hFFFF; with SCAN_CHECK_EN, mismatch=1 and mismatch_map=16'hF98A.
REQ-031 SETTLE=3, S = X1 -> X held 4 cycles per index, done at edge k+64, table_out=16'hAAAA.
REQ-032 start re-pulsed at cycle 10 of a scan -> ignored; done still at edge k+32 and the table is unchanged.
REQ-033 rst_n asserted at cycle 20 of a scan, between clock edges -> busy, done, X1..X4 and table_out go to 0 immediately; no done until a new start.
REQ-034 start held high continuously -> successive scans with done high one cycle each, period 33 cycles (SETTLE=1).

Source files
------------

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps a 4-bit stimulus index through all 16 values and
// captures the response S of the function under scan. Optional SCAN_CHECK_EN adds a golden compare.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h0675
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        S,
  output logic        X1,
  output logic        X2,
  output logic        X3,
  output logic        X4,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out
`ifdef SCAN_CHECK_EN
  ,
  output logic        mismatch,
  output logic [15:0] mismatch_map
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] tbl, tbl_nxt;
  logic [3:0]  x_q;
  logic        busy_q, done_q;
  logic        scanning_nxt;

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    tbl_nxt   = tbl;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          idx_nxt   = 4'd0;
          cnt_nxt   = 4'd0;
          tbl_nxt   = 16'h0000;
        end
      end
      ST_SETTLE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        tbl_nxt[idx] = S;
        if (idx == 4'd15) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
          idx_nxt   = idx + 4'd1;
          cnt_nxt   = 4'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign scanning_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order of statements here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= 4'd0;
      cnt    <= 4'd0;
      tbl    <= 16'h0000;
      x_q    <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      tbl    <= tbl_nxt;
      // Stimulus is registered from the next index so it lines up with the state.
      x_q    <= scanning_nxt ? idx_nxt : 4'd0;
      busy_q <= scanning_nxt;
      done_q <= (state_nxt == ST_DONE);
    end
  end

  assign X1        = x_q[0];
  assign X2        = x_q[1];
  assign X3        = x_q[2];
  assign X4        = x_q[3];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = tbl;

`ifdef SCAN_CHECK_EN
  // Only a completed table is meaningful, so the compare is gated by done.
  assign mismatch_map = done_q ? (tbl ^ EXPECTED) : 16'h0000;
  assign mismatch     = |mismatch_map;
`endif

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy_q && done_q));
  a_x_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !busy_q |-> (x_q == 4'd0));

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3),
// table-driven scans, hand-written corner sequences and randomized scans vs a behavioural model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start1, start3;
  logic [15:0] fn1, fn3;
  logic        ux1, ux3;
  wire logic [3:0]  xa, xb;
  wire logic        busy1, busy3, done1, done3;
  wire logic [15:0] tbl1, tbl3;
  wire logic        s1, s3;
`ifdef SCAN_CHECK_EN
  wire logic        mm1, mm3;
  wire logic [15:0] map1, map3;
`endif

  assign s1 = ux1 ? xa[0] : fn1[xa];
  assign s3 = ux3 ? xb[0] : fn3[xb];

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .S(s1),
    .X1(xa[0]), .X2(xa[1]), .X3(xa[2]), .X4(xa[3]),
    .busy(busy1), .done(done1), .table_out(tbl1)
`ifdef SCAN_CHECK_EN
    , .mismatch(mm1), .mismatch_map(map1)
`endif
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .S(s3),
    .X1(xb[0]), .X2(xb[1]), .X3(xb[2]), .X4(xb[3]),
    .busy(busy3), .done(done3), .table_out(tbl3)
`ifdef SCAN_CHECK_EN
    , .mismatch(mm3), .mismatch_map(map3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_x(input int w);
    return (w == 3) ? {12'h0, xb} : {12'h0, xa};
  endfunction
  function automatic logic [15:0] get_busy(input int w);
    return (w == 3) ? {15'h0, busy3} : {15'h0, busy1};
  endfunction
  function automatic logic [15:0] get_done(input int w);
    return (w == 3) ? {15'h0, done3} : {15'h0, done1};
  endfunction
  function automatic logic [15:0] get_tbl(input int w);
    return (w == 3) ? tbl3 : tbl1;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 3) start3 = v; else start1 = v;
  endtask

  // Reference: table bit i is the function's value at input i.
  function automatic logic [15:0] model_table(input logic [15:0] fn, input bit use_x1);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = use_x1 ? i[0] : fn[i];
    return t;
  endfunction

  task automatic check_done_state(input int w, input logic [15:0] exp_tbl, input logic [15:0] exp_map);
    check("done_high", get_done(w), 16'h1);
    check("busy_low_at_done", get_busy(w), 16'h0);
    check("table_out", get_tbl(w), exp_tbl);
    check("x_zero_at_done", get_x(w), 16'h0);
`ifdef SCAN_CHECK_EN
    check("mismatch_map", (w == 3) ? map3 : map1, exp_map);
    check("mismatch", {15'h0, (w == 3) ? mm3 : mm1}, {15'h0, |exp_map});
`else
    if (exp_map === 16'hxxxx) check("map_placeholder", exp_map, 16'h0);
`endif
  endtask

  // Starts a scan at edge k and follows it edge by edge until done is due.
  task automatic run_scan(input int w, input logic [15:0] fn, input bit use_x1,
                          input int repulse, input logic [15:0] exp_tbl,
                          input logic [15:0] exp_map);
    int per, total;
    per   = w + 1;
    total = 16 * per;
    if (w == 3) begin fn3 = fn; ux3 = use_x1; end
    else        begin fn1 = fn; ux1 = use_x1; end
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    check("busy_after_start", get_busy(w), 16'h1);
    check("done_after_start", get_done(w), 16'h0);
    check("table_cleared", get_tbl(w), 16'h0);
    check("x_first", get_x(w), 16'h0);
`ifdef SCAN_CHECK_EN
    check("map_during_scan", (w == 3) ? map3 : map1, 16'h0);
`endif
    for (int t = 1; t < total; t++) begin
      @(posedge clk); #1;
      check("x_seq", get_x(w), 16'(t / per));
      if (t % per == 0 && t / per == 8)
        check("partial_table", get_tbl(w), exp_tbl & 16'h00FF);
      if (t == total - 1) check("no_early_done", get_done(w), 16'h0);
      if (t == repulse) set_start(w, 1'b1);
      if (t == repulse + 1) set_start(w, 1'b0);
    end
    @(posedge clk); #1;
    check_done_state(w, exp_tbl, exp_map);
  endtask

  typedef struct {
    int          which;
    logic [15:0] fn;
    bit          use_x1;
    int          repulse;
    logic [15:0] exp_tbl;
    logic [15:0] exp_map;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 16'h0675, 1'b0, -1, 16'h0675, 16'h0000};
    vecs[1] = '{1, 16'hFFFF, 1'b0, -1, 16'hFFFF, 16'hF98A};
    vecs[2] = '{3, 16'h0000, 1'b1, -1, 16'hAAAA, 16'hACDF};
    vecs[3] = '{1, 16'h0675, 1'b0, 10, 16'h0675, 16'h0000};
    vecs[4] = '{1, 16'h0000, 1'b0, -1, 16'h0000, 16'h0675};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    fn1 = 16'h0; fn3 = 16'h0; ux1 = 1'b0; ux3 = 1'b0;
    #23;
    check("reset_busy", get_busy(1), 16'h0);
    check("reset_done", get_done(1), 16'h0);
    check("reset_table", get_tbl(1), 16'h0);
    check("reset_x", get_x(1), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_activity", get_busy(1), 16'h0);

    for (int i = 0; i < 5; i++)
      run_scan(vecs[i].which, vecs[i].fn, vecs[i].use_x1, vecs[i].repulse,
               vecs[i].exp_tbl, vecs[i].exp_map);

    // DONE holds its result while start stays low.
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", get_done(1), 16'h1);
    check("table_hold", get_tbl(1), 16'h0000);

    // Asynchronous reset between edges in the middle of a scan.
    fn1 = 16'h0675; ux1 = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("pre_reset_partial", tbl1, 16'h0675 & 16'h03FF);
    rst_n = 1'b0;
    #1;
    check("async_busy", get_busy(1), 16'h0);
    check("async_done", get_done(1), 16'h0);
    check("async_x", get_x(1), 16'h0);
    check("async_table", get_tbl(1), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_reset", get_done(1), 16'h0);
    check("no_busy_after_reset", get_busy(1), 16'h0);

    // First edge after reset release with start high is accepted.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin rst_n = 1'b1; start1 = 1'b1; end
    @(posedge clk); #1; start1 = 1'b0;
    check("first_edge_accept", get_busy(1), 16'h1);
    repeat (31) @(posedge clk);
    #1;
    check("first_edge_no_early_done", get_done(1), 16'h0);
    @(posedge clk); #1;
    check_done_state(1, 16'h0675, 16'h0000);

    // start held high: back-to-back scans, done one cycle each, period 33.
    fn1 = 16'h5A3C;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      check("cont_done", get_done(1), {15'h0, (t % 33 == 32)});
      if (t % 33 == 32) check("cont_table", get_tbl(1), 16'h5A3C);
    end
    start1 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("cont_final_done", get_done(1), 16'h1);

    // Randomized scans against the behavioural model.
    for (int r = 0; r < 8; r++) begin
      int w, rp;
      logic [15:0] fn, et;
      bit ux;
      w  = ($urandom_range(0, 1) == 0) ? 1 : 3;
      fn = 16'($urandom);
      ux = ($urandom_range(0, 4) == 0);
      rp = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 16 * (w + 1) - 4));
      et = model_table(fn, ux);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_scan(w, fn, ux, rp, et, et ^ 16'h0675);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
